// File: rtl/lv_reg_rd_arb.sv
// Shared register-bank read port arbiter: SPI read path vs watchdog scan path.
// Optional scan anti-starvation logic is enabled by defining LV_RD_ARB_STARVE_EN.
module lv_reg_rd_arb #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int RD_LAT    = 1,
  parameter int STARVE_TH = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_spi_rd_req,
  input  logic [REG_AW-1:0]    i_spi_rd_addr,
  output logic                 o_spi_rd_ack,
  output logic [REG_DW-1:0]    o_spi_rd_data,
  input  logic                 i_wdg_rd_req,
  input  logic [REG_AW-1:0]    i_wdg_rd_addr,
  output logic                 o_wdg_rd_ack,
  output logic [REG_DW-1:0]    o_wdg_rd_data,
  output logic [REG_CRC_W-1:0] o_wdg_rd_crc,
  output logic                 o_rb_rd_en,
  output logic [REG_AW-1:0]    o_rb_rd_addr,
  input  logic [REG_DW-1:0]    i_rb_rd_data,
  input  logic [REG_CRC_W-1:0] i_rb_rd_crc,
  output logic                 o_busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                 state_q, state_d;
  logic                   owner_wdg_q, owner_wdg_d;
  logic [REG_AW-1:0]      addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic                   spi_ack_q, spi_ack_d;
  logic                   wdg_ack_q, wdg_ack_d;
  logic [REG_DW-1:0]      spi_data_q, spi_data_d;
  logic [REG_DW-1:0]      wdg_data_q, wdg_data_d;
  logic [REG_CRC_W-1:0]   wdg_crc_q, wdg_crc_d;
  logic                   starve_flag;
  logic                   grant_wdg;

  // Scan wins only when SPI is absent or the scan request has waited too long.
  assign grant_wdg = i_wdg_rd_req && (!i_spi_rd_req || starve_flag);

`ifdef LV_RD_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_TH + 1);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!i_wdg_rd_req || (state_q == S_IDLE && grant_wdg)) begin
      starve_d = '0;
    end else if (!(state_q != S_IDLE && owner_wdg_q) && starve_q != SW'(STARVE_TH)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end

  assign starve_flag = (starve_q == SW'(STARVE_TH));
`else
  assign starve_flag = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_wdg_d = owner_wdg_q;
    addr_d      = addr_q;
    rd_en_d     = 1'b0;
    lat_d       = lat_q;
    spi_ack_d   = 1'b0;
    wdg_ack_d   = 1'b0;
    spi_data_d  = spi_data_q;
    wdg_data_d  = wdg_data_q;
    wdg_crc_d   = wdg_crc_q;
    case (state_q)
      S_IDLE: begin
        if (i_spi_rd_req || i_wdg_rd_req) begin
          owner_wdg_d = grant_wdg;
          addr_d      = grant_wdg ? i_wdg_rd_addr : i_spi_rd_addr;
          rd_en_d     = 1'b1;
          lat_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_ACK;
          // An owner that withdrew its request gets neither ack nor new data.
          if (owner_wdg_q) begin
            if (i_wdg_rd_req) begin
              wdg_ack_d  = 1'b1;
              wdg_data_d = i_rb_rd_data;
              wdg_crc_d  = i_rb_rd_crc;
            end
          end else if (i_spi_rd_req) begin
            spi_ack_d  = 1'b1;
            spi_data_d = i_rb_rd_data;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      owner_wdg_q <= 1'b0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      lat_q       <= '0;
      spi_ack_q   <= 1'b0;
      wdg_ack_q   <= 1'b0;
      spi_data_q  <= '0;
      wdg_data_q  <= '0;
      wdg_crc_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_wdg_q <= owner_wdg_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      lat_q       <= lat_d;
      spi_ack_q   <= spi_ack_d;
      wdg_ack_q   <= wdg_ack_d;
      spi_data_q  <= spi_data_d;
      wdg_data_q  <= wdg_data_d;
      wdg_crc_q   <= wdg_crc_d;
    end
  end

  assign o_spi_rd_ack  = spi_ack_q;
  assign o_spi_rd_data = spi_data_q;
  assign o_wdg_rd_ack  = wdg_ack_q;
  assign o_wdg_rd_data = wdg_data_q;
  assign o_wdg_rd_crc  = wdg_crc_q;
  assign o_rb_rd_en    = rd_en_q;
  assign o_rb_rd_addr  = addr_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule
